cache_refill: RTL and testbench

CACHE_REFILL -- requirements
Module: cache_refill

---
 rtl/cache_refill.sv | 108 ++++++++++
 tb/tb_cache_refill.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cache_refill.sv
// Cache block refill controller: fetches a 4-word block over a simple read/ack bus, then pulses overwrite.
// Optional critical-word-first ordering is enabled by defining CACHE_REFILL_CWF_EN.
module cache_refill #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic                  hit_in,
    output logic                  mem_rd,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [DATA_WIDTH-1:0] data1,
    output logic [DATA_WIDTH-1:0] data2,
    output logic [DATA_WIDTH-1:0] data3,
    output logic [DATA_WIDTH-1:0] data4,
    output logic                  overwrite,
    output logic                  stall,
    output logic [1:0]            fsm_state
);
    // Memory handshake: mem_rd is held with a stable mem_addr until a cycle with mem_ack=1,
    // which both accepts the request and returns mem_rdata for that beat.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FILL  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [DATA_WIDTH-5:0]   block_tag;
    logic [1:0]              start_off;
    logic [1:0]              beat;
    logic [1:0]              offset;
    logic [DATA_WIDTH-1:0]   blk [4];
    logic                    miss;
    logic                    unused_addr_bits;

    assign miss      = req_valid && !hit_in;
    assign offset    = start_off + beat;
    // The block tag and 2-bit offset are concatenated, so the address cannot carry out of the block.
    assign mem_addr  = {block_tag, offset, 2'b00};
    assign data1     = blk[0];
    assign data2     = blk[1];
    assign data3     = blk[2];
    assign data4     = blk[3];
    assign fsm_state = state;
    assign unused_addr_bits = &{1'b0, addr[3:0]};

    always_comb begin
        state_nxt = state;
        mem_rd    = 1'b0;
        overwrite = 1'b0;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                stall = miss;
                if (miss) state_nxt = FETCH;
            end
            FETCH: begin
                mem_rd = 1'b1;
                stall  = 1'b1;
                if (mem_ack && beat == 2'd3) state_nxt = FILL;
            end
            FILL: begin
                // A reset arriving in this cycle cancels the pulse.
                overwrite = !rst;
                stall     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            block_tag <= '0;
            start_off <= 2'd0;
            beat      <= 2'd0;
            for (int i = 0; i < 4; i++) blk[i] <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (miss) begin
                        block_tag <= addr[DATA_WIDTH-1:4];
`ifdef CACHE_REFILL_CWF_EN
                        start_off <= addr[3:2];
`else
                        start_off <= 2'd0;
`endif
                        beat      <= 2'd0;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        blk[offset] <= mem_rdata;
                        beat        <= beat + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_refill.sv
// Self-checking bench for cache_refill: directed scenarios plus random traffic against a block-level model.
module tb_cache_refill;
    localparam int W = 32;
`ifdef CACHE_REFILL_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, req_valid, hit_in, mem_ack;
    logic [W-1:0] addr, mem_rdata;
    logic         mem_rd, overwrite, stall;
    logic [W-1:0] mem_addr, data1, data2, data3, data4;
    logic [1:0]   fsm_state;

    cache_refill #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .addr(addr), .hit_in(hit_in),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .data1(data1), .data2(data2), .data3(data3), .data4(data4),
        .overwrite(overwrite), .stall(stall), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Model: phase 0 = no refill, 1 = collecting beats, 2 = block complete.
    int           mode = 0;
    logic [W-1:0] m_base = '0;
    logic [1:0]   exp_q[$];
    logic [W-1:0] m_data[4] = '{default: '0};

    int           cnum = 0, ow_cnt = 0, ow_at = -1, stall_cnt = 0;
    logic [W-1:0] last_addr;
    logic         last_rd;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cnum);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cnum);
        end
    endtask

    task automatic step(input logic r, input logic rv, input logic [W-1:0] a, input logic h,
                        input logic ak, input logic [W-1:0] rd);
        logic [1:0] st;
        @(negedge clk);
        rst = r; req_valid = rv; addr = a; hit_in = h; mem_ack = ak; mem_rdata = rd;
        #1;
        chk1("stall", stall, (mode != 0) || (rv && !h));
        chk1("mem_rd", mem_rd, mode == 1);
        chk1("overwrite", overwrite, (mode == 2) && !r);
        if (mode == 1) chk("mem_addr", mem_addr, m_base + 4 * W'(exp_q[0]));
        chk("data1", data1, m_data[0]);
        chk("data2", data2, m_data[1]);
        chk("data3", data3, m_data[2]);
        chk("data4", data4, m_data[3]);
        if (overwrite) begin ow_cnt++; ow_at = cnum; end
        if (stall) stall_cnt++;
        last_addr = mem_addr;
        last_rd   = mem_rd;
        @(posedge clk);
        if (r) begin
            mode = 0;
            exp_q.delete();
            for (int i = 0; i < 4; i++) m_data[i] = '0;
        end else begin
            case (mode)
                0: if (rv && !h) begin
                    m_base = a & ~W'(32'hF);
                    st = CWF ? a[3:2] : 2'd0;
                    exp_q.delete();
                    for (int k = 0; k < 4; k++) exp_q.push_back(2'(int'(st) + k));
                    mode = 1;
                end
                1: if (ak) begin
                    m_data[exp_q[0]] = rd;
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) mode = 2;
                end
                default: mode = 0;
            endcase
        end
        cnum++;
    endtask

    initial begin
        int c0;
        logic [W-1:0] got_addr[4];
        logic [W-1:0] exp_addr[4];
        logic [W-1:0] exp_dat[4];
        logic [W-1:0] saved[4];

        rst = 1'b1; req_valid = 1'b0; addr = '0; hit_in = 1'b0; mem_ack = 1'b0; mem_rdata = '0;

        // Reset state
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        #1;
        chk("rst_mem_addr", mem_addr, 0);
        chk1("rst_mem_rd", mem_rd, 1'b0);
        chk1("rst_overwrite", overwrite, 1'b0);
        chk("rst_data1", data1, 0);
        chk("rst_data4", data4, 0);

        // Miss at 0x104, ack every cycle
        ow_cnt = 0; stall_cnt = 0; c0 = cnum;
        step(0, 1, 32'h104, 0, 1, 32'hDEAD);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1, 32'hA0 + W'(i));
            got_addr[i] = last_addr;
        end
        step(0, 0, 0, 0, 1, 32'hBAD0);
        step(0, 0, 0, 0, 1, 32'hBAD1);
        step(0, 0, 0, 0, 0, 0);
        exp_addr = CWF ? '{32'h104, 32'h108, 32'h10C, 32'h100} : '{32'h100, 32'h104, 32'h108, 32'h10C};
        exp_dat  = CWF ? '{32'hA3, 32'hA0, 32'hA1, 32'hA2} : '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        for (int i = 0; i < 4; i++) chk("beat_addr", got_addr[i], exp_addr[i]);
        #1;
        chk("blk_data1", data1, exp_dat[0]);
        chk("blk_data2", data2, exp_dat[1]);
        chk("blk_data3", data3, exp_dat[2]);
        chk("blk_data4", data4, exp_dat[3]);
        chk("ow_delay", W'(ow_at - c0), 5);
        chk("ow_count", W'(ow_cnt), 1);
        chk("stall_cycles", W'(stall_cnt), 6);

        // Two wait cycles before every beat
        ow_cnt = 0; c0 = cnum;
        step(0, 1, 32'h208, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 32'h500, 0, 0, $urandom);
            step(0, 0, 0, 0, 0, $urandom);
            step(0, 0, 0, 0, 1, 32'hB0 + W'(i));
        end
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        exp_dat = CWF ? '{32'hB2, 32'hB3, 32'hB0, 32'hB1} : '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
        #1;
        chk("wait_data1", data1, exp_dat[0]);
        chk("wait_data3", data3, exp_dat[2]);
        chk("wait_ow_delay", W'(ow_at - c0), 13);
        chk("wait_ow_count", W'(ow_cnt), 1);

        // Reset after the second acked beat
        ow_cnt = 0;
        step(0, 1, 32'h300, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'hC0);
        step(0, 0, 0, 0, 1, 32'hC1);
        step(1, 1, 32'h340, 0, 1, 32'hC2);
        #1;
        chk1("abort_mem_rd", mem_rd, 1'b0);
        chk("abort_data1", data1, 0);
        chk("abort_data2", data2, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, $urandom);
        chk("abort_ow_count", W'(ow_cnt), 0);

        // Top-of-memory block, with a competing miss presented during the refill
        ow_cnt = 0;
        step(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            step(0, 1, 32'h200, 0, 1'($urandom_range(0, 1)), $urandom);
            if (last_rd) chk("wrap_block", last_addr & 32'hFFFF_FFF0, 32'hFFFF_FFF0);
            if (mode == 0) break;
        end
        chk("wrap_ow_count", W'(ow_cnt), 1);

        // Hit and stray acks leave the block alone
        saved = '{data1, data2, data3, data4};
        stall_cnt = 0;
        for (int i = 0; i < 3; i++) step(0, 1, 32'h400, 1, 1, $urandom);
        #1;
        chk("hit_stall_cycles", W'(stall_cnt), 0);
        chk1("hit_mem_rd", mem_rd, 1'b0);
        chk("hit_data1", data1, saved[0]);
        chk("hit_data4", data4, saved[3]);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)),
                 (i % 7 == 0) ? 32'hFFFF_FFF0 | W'($urandom_range(0, 15)) : $urandom,
                 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
